// File: rtl/demux_1to8_scheduler_pkg.sv
// Shared sizes and FSM encoding for the round-robin 1-to-8 demux sequencer.
package demux_1to8_scheduler_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int FCNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1to8_scheduler_demux.sv
// Plain 1-to-8 demultiplexer: din appears on output bit [sel] when enabled.
module demux_1to8
    import demux_1to8_scheduler_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    input  logic              din,
    output logic [NUM_CH-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = din;
        end
    end

endmodule

// File: rtl/demux_1to8_scheduler_next_channel_finder.sv
// Combinational search over a channel mask: lowest set bit, and the next set
// bit strictly above a current pointer (wrap when there is none).
module next_channel_finder
    import demux_1to8_scheduler_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next,
    output logic              wrap,
    output logic [SEL_W-1:0]  first,
    output logic              any
);

    // Descending scan so the last hit written is the lowest qualifying index.
    always_comb begin
        first = '0;
        next  = '0;
        wrap  = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = SEL_W'(i);
            end
            if (mask[i] && (i > int'(cur))) begin
                next = SEL_W'(i);
                wrap = 1'b0;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/demux_1to8_scheduler.sv
// Round-robin sequencer steering a serial bit stream across the enabled
// channels of a 1-to-8 demux, with round counting and drop reporting.
module demux_1to8_scheduler
    import demux_1to8_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_data,
    input  logic              frame_start,
    input  logic [NUM_CH-1:0] chan_en,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] out_valid,
    output logic [SEL_W-1:0]  select,
    output logic [FCNT_W-1:0] frame_count,
    output logic              drop,
    output logic              idle
);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   act_mask;
    logic [SEL_W-1:0]    sel_q;
    logic [FCNT_W-1:0]   fcnt_q;

    logic [NUM_CH-1:0]   out_p1;
    logic [NUM_CH-1:0]   vld_p1;
    logic                drop_p1;

    logic                accept;
    logic                drop_d;
    logic                load_mask;
    logic                fcnt_inc;
    logic [SEL_W-1:0]    sel_d;
    logic [SEL_W-1:0]    route_sel;

    logic [SEL_W-1:0]    en_first;
    logic                en_any;
    logic [SEL_W-1:0]    en_next;
    logic                en_wrap;

    logic [NUM_CH-1:0]   adv_mask;
    logic [SEL_W-1:0]    adv_cur;
    logic [SEL_W-1:0]    adv_next;
    logic                adv_wrap;
    logic [SEL_W-1:0]    adv_first;
    logic                adv_any;

    logic [NUM_CH-1:0]   out_p0;
    logic [NUM_CH-1:0]   vld_p0;

    // Restart/reload target: lowest channel of the live software mask.
    next_channel_finder u_en_finder (
        .mask  (chan_en),
        .cur   (sel_q),
        .next  (en_next),
        .wrap  (en_wrap),
        .first (en_first),
        .any   (en_any)
    );

    // On frame_start the pointer advances from the restart channel within the
    // freshly loaded mask; otherwise from the current pointer in the shadow mask.
    assign adv_mask = frame_start ? chan_en  : act_mask;
    assign adv_cur  = frame_start ? en_first : sel_q;

    next_channel_finder u_adv_finder (
        .mask  (adv_mask),
        .cur   (adv_cur),
        .next  (adv_next),
        .wrap  (adv_wrap),
        .first (adv_first),
        .any   (adv_any)
    );

    logic unused_finder;
    assign unused_finder = ^{en_next, en_wrap, adv_first, adv_any};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_mask) begin
            state_nxt = en_any ? RUN : IDLE;
        end
    end

    always_comb begin
        accept    = 1'b0;
        drop_d    = 1'b0;
        load_mask = 1'b0;
        fcnt_inc  = 1'b0;
        sel_d     = sel_q;
        route_sel = sel_q;
        case (state)
            IDLE: begin
                load_mask = 1'b1;
                sel_d     = en_first;
                drop_d    = in_valid;
            end
            RUN: begin
                if (frame_start) begin
                    load_mask = 1'b1;
                    route_sel = en_first;
                    if (!en_any) begin
                        sel_d  = '0;
                        drop_d = in_valid;
                    end else if (in_valid) begin
                        accept = 1'b1;
                        if (adv_wrap) begin
                            fcnt_inc = 1'b1;
                            sel_d    = en_first;
                        end else begin
                            sel_d = adv_next;
                        end
                    end else begin
                        sel_d = en_first;
                    end
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (adv_wrap) begin
                        fcnt_inc  = 1'b1;
                        load_mask = 1'b1;
                        sel_d     = en_first;
                    end else begin
                        sel_d = adv_next;
                    end
                end
            end
            default: begin
                load_mask = 1'b1;
                sel_d     = en_first;
                drop_d    = in_valid;
            end
        endcase
    end

    // Stage p0: demux the accepted bit onto its channel, data and valid lanes.
    demux_1to8 u_data_demux (
        .sel (route_sel),
        .en  (accept),
        .din (in_data),
        .y   (out_p0)
    );

    demux_1to8 u_valid_demux (
        .sel (route_sel),
        .en  (accept),
        .din (1'b1),
        .y   (vld_p0)
    );

    // Stage p1: registered outputs and sequencing state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_p1   <= '0;
            vld_p1   <= '0;
            drop_p1  <= 1'b0;
            sel_q    <= '0;
            act_mask <= '0;
            fcnt_q   <= '0;
        end else begin
            out_p1  <= out_p0;
            vld_p1  <= vld_p0;
            drop_p1 <= drop_d;
            sel_q   <= sel_d;
            if (load_mask) begin
                act_mask <= chan_en;
            end
            if (fcnt_inc) begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
        end
    end

    assign out         = out_p1;
    assign out_valid   = vld_p1;
    assign drop        = drop_p1;
    assign select      = sel_q;
    assign frame_count = fcnt_q;
    assign idle        = (state == IDLE);

endmodule

// File: tb/tb_demux_1to8_scheduler.sv
// Scoreboard bench for demux_1to8_scheduler: directed vectors push expected
// outputs, a negedge monitor pops and compares whenever the DUT emits.
module tb_demux_1to8_scheduler;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_data;
    logic       frame_start;
    logic [7:0] chan_en;
    logic [7:0] out;
    logic [7:0] out_valid;
    logic [2:0] select;
    logic [7:0] frame_count;
    logic       drop;
    logic       idle;

    demux_1to8_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .frame_start (frame_start),
        .chan_en     (chan_en),
        .out         (out),
        .out_valid   (out_valid),
        .select      (select),
        .frame_count (frame_count),
        .drop        (drop),
        .idle        (idle)
    );

    typedef struct packed {
        logic [7:0] ov;
        logic [7:0] d;
        logic       drp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && ((|out_valid) || (|out) || drop)) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected got ov=%h out=%h drop=%b, required no output", out_valid, out, drop);
            end else begin
                e = q.pop_front();
                if ({out_valid, out, drop} !== e) begin
                    n_fail++;
                    $display("FAIL sb_output got ov=%h out=%h drop=%b, required ov=%h out=%h drop=%b",
                             out_valid, out, drop, e.ov, e.d, e.drp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic d);
        exp_t x;
        x.ov  = 8'h01 << ch;
        x.d   = d ? (8'h01 << ch) : 8'h00;
        x.drp = 1'b0;
        q.push_back(x);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic push_drop();
        exp_t x;
        x.ov  = 8'h00;
        x.d   = 8'h00;
        x.drp = 1'b1;
        q.push_back(x);
    endtask

    initial begin
        logic [15:0] pat;
        int t2 [6];
        int t3 [8];
        pat = 16'hB3D5;
        t2  = '{2, 5, 7, 2, 5, 7};
        t3  = '{5, 6, 7, 0, 1, 2, 3, 0};

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 1'b0;
        frame_start = 1'b0;
        chan_en     = 8'hFF;
        #3;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_select", 32'(select), 32'h0);
        chk("reset_frame_count", 32'(frame_count), 32'h0);
        chk("reset_drop", 32'(drop), 32'h0);
        chk("reset_idle", 32'(idle), 32'h1);
        tick();
        reset = 1'b0;
        tick();
        chk("load_ff_idle", 32'(idle), 32'h0);
        chk("load_ff_select", 32'(select), 32'h0);

        // All channels enabled: two full rounds.
        for (int i = 0; i < 16; i++) begin
            send(i % 8, pat[i]);
            chk("walk_select", 32'(select), 32'((i + 1) % 8));
        end
        chk("walk_frame_count", 32'(frame_count), 32'd2);

        // Sparse mask 1010_0100 loaded by frame_start.
        in_valid    = 1'b0;
        chan_en     = 8'hA4;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("sparse_start_select", 32'(select), 32'd2);
        chk("sparse_start_fcount", 32'(frame_count), 32'd2);
        for (int j = 0; j < 6; j++) begin
            send(t2[j], j[0]);
        end
        chk("sparse_frame_count", 32'(frame_count), 32'd4);
        chk("sparse_select", 32'(select), 32'd2);

        // Mid-round mask change only takes effect after the wrap.
        in_valid    = 1'b0;
        chan_en     = 8'hFF;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("mid_restart_select", 32'(select), 32'd0);
        for (int j = 0; j < 5; j++) begin
            send(j, 1'b1);
        end
        chk("mid_select5", 32'(select), 32'd5);
        chan_en = 8'h0F;
        for (int j = 0; j < 8; j++) begin
            send(t3[j], 1'b1);
        end
        chk("mid_frame_count", 32'(frame_count), 32'd6);
        chk("mid_select", 32'(select), 32'd1);

        // frame_start with a coincident bit at select=4, mask 0011_0000.
        in_valid    = 1'b0;
        chan_en     = 8'hFF;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            send(j, 1'b1);
        end
        chk("fs_pre_select", 32'(select), 32'd4);
        chan_en     = 8'h30;
        frame_start = 1'b1;
        send(4, 1'b1);
        frame_start = 1'b0;
        chk("fs_select", 32'(select), 32'd5);
        chk("fs_frame_count", 32'(frame_count), 32'd6);
        send(5, 1'b0);
        chk("fs_wrap_frame_count", 32'(frame_count), 32'd7);
        chk("fs_wrap_select", 32'(select), 32'd4);

        // Zero mask: coincident frame_start bit and two idle bits all dropped.
        chan_en     = 8'h00;
        frame_start = 1'b1;
        in_valid    = 1'b1;
        in_data     = 1'b1;
        push_drop();
        tick();
        frame_start = 1'b0;
        push_drop();
        tick();
        push_drop();
        tick();
        in_valid = 1'b0;
        chk("zero_idle", 32'(idle), 32'h1);
        chk("zero_select", 32'(select), 32'h0);
        tick();
        chk("zero_frame_count", 32'(frame_count), 32'd7);
        chk("zero_out_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-round at select=6, frame_count=9.
        chan_en = 8'hFF;
        tick();
        for (int j = 0; j < 22; j++) begin
            send(j % 8, (j % 3) == 0);
        end
        in_valid = 1'b0;
        chk("prereset_frame_count", 32'(frame_count), 32'd9);
        chk("prereset_select", 32'(select), 32'd6);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_out", 32'(out), 32'h0);
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_select", 32'(select), 32'h0);
        chk("async_frame_count", 32'(frame_count), 32'h0);
        chk("async_idle", 32'(idle), 32'h1);
        chan_en = 8'h28;
        tick();
        reset = 1'b0;
        tick();
        chk("postreset_select", 32'(select), 32'd3);
        send(3, 1'b1);
        in_valid = 1'b0;
        chk("postreset_next_select", 32'(select), 32'd5);
        tick();
        tick();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
